// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN inference sequencer.
package snn_pkg;

   typedef enum logic [2:0] {
      LOAD_WAIT,
      LOAD_BITS,
      RUN_START,
      RUN_WAIT,
      TX,
      TX_WAIT
   } ctrl_state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_ERR  = 8'h3F;
   localparam int         NUM_PIX    = 784;

   // Digits above 9 have no single ASCII digit, so they report as '?'.
   function automatic logic [7:0] digit_ascii(input logic [3:0] d, input logic err);
      if (err || (d > 4'd9)) return ASCII_ERR;
      return ASCII_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/snn_ctrl_if.sv
// Bundle of UART, input-RAM, core and status signals around the sequencer.
interface snn_ctrl_if #(parameter int ADDR_W = 10) ();

   logic                      rx_rdy;
   logic [7:0]                rx_data;
   logic                      clr_rx_rdy;
   logic [ADDR_W-1:0]         ram_addr;
   logic                      ram_d;
   logic                      ram_we;
   logic [ADDR_W-1:0]         core_addr;
   logic                      core_start;
   logic                      core_done;
   logic [3:0]                core_digit;
   logic                      tx_start;
   logic [7:0]                tx_data;
   logic                      tx_done;
   logic [3:0]                digit;
   logic                      busy;
   snn_pkg::ctrl_state_t      state;

   // Handshakes: rx_rdy is a level held until a one-cycle clr_rx_rdy;
   // core_start/core_done and tx_start/tx_done are single-cycle pulses.
   modport master (
      input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
      output clr_rx_rdy, ram_addr, ram_d, ram_we, core_start,
             tx_start, tx_data, digit, busy, state
   );

   modport slave (
      output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
      input  clr_rx_rdy, ram_addr, ram_d, ram_we, core_start,
             tx_start, tx_data, digit, busy, state
   );

endinterface

// File: rtl/snn_byte_unpack.sv
// Byte-to-bit serializer: LSB first, with a flag on the eighth bit.
module snn_byte_unpack (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       advance,
   input  logic [7:0] data,
   output logic       bit_out,
   output logic       last
);

   logic [7:0] shift;
   logic [2:0] bit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift   <= 8'h00;
         bit_cnt <= 3'd0;
      end else if (load) begin
         shift   <= data;
         bit_cnt <= 3'd0;
      end else if (advance) begin
         shift   <= shift >> 1;
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   assign bit_out = shift[0];
   assign last    = (bit_cnt == 3'd7);

endmodule

// File: rtl/snn_ctrl.sv
// Top sequencer: loads an image bit-serially, runs the core, reports the digit.
module snn_ctrl #(
   parameter int NUM_PIX     = 784,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 65535
) (
   input logic        clk,
   input logic        rst,
   snn_ctrl_if.master bus
);
   import snn_pkg::*;

   ctrl_state_t       state, state_nxt;
   logic [ADDR_W-1:0] pix_cnt;
   logic [15:0]       timer;
   logic              err;
   logic [3:0]        digit_q;
   logic [7:0]        tx_data_q;
   logic              unpack_load, unpack_adv, bit_out, last_bit;
   logic              last_pix, timed_out;

   assign last_pix  = (pix_cnt == ADDR_W'(NUM_PIX - 1));
   assign timed_out = (timer == 16'(TIMEOUT_CYC));

   snn_byte_unpack u_unpack (
      .clk     (clk),
      .rst     (rst),
      .load    (unpack_load),
      .advance (unpack_adv),
      .data    (bus.rx_data),
      .bit_out (bit_out),
      .last    (last_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD_WAIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.clr_rx_rdy = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_d      = 1'b0;
      bus.ram_addr   = pix_cnt;
      bus.core_start = 1'b0;
      bus.tx_start   = 1'b0;
      unpack_load    = 1'b0;
      unpack_adv     = 1'b0;
      case (state)
         LOAD_WAIT: begin
            if (bus.rx_rdy) begin
               bus.clr_rx_rdy = 1'b1;
               unpack_load    = 1'b1;
               state_nxt      = LOAD_BITS;
            end
         end
         LOAD_BITS: begin
            bus.ram_we = 1'b1;
            bus.ram_d  = bit_out;
            unpack_adv = 1'b1;
            if (last_bit) state_nxt = last_pix ? RUN_START : LOAD_WAIT;
         end
         RUN_START: begin
            bus.ram_addr   = bus.core_addr;
            bus.core_start = 1'b1;
            state_nxt      = RUN_WAIT;
         end
         RUN_WAIT: begin
            bus.ram_addr = bus.core_addr;
            if (bus.core_done || timed_out) state_nxt = TX;
         end
         TX: begin
            bus.ram_addr = bus.core_addr;
            bus.tx_start = 1'b1;
            state_nxt    = TX_WAIT;
         end
         TX_WAIT: begin
            bus.ram_addr = bus.core_addr;
            if (bus.tx_done) state_nxt = LOAD_WAIT;
         end
         default: state_nxt = LOAD_WAIT;
      endcase
   end

   // tx_data is captured on the way into TX so it is stable for the whole send.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt   <= '0;
         timer     <= 16'd0;
         err       <= 1'b0;
         digit_q   <= 4'd0;
         tx_data_q <= 8'h00;
      end else begin
         case (state)
            LOAD_BITS: pix_cnt <= (last_bit && last_pix) ? '0 : pix_cnt + 1'b1;
            RUN_START: timer   <= 16'd0;
            RUN_WAIT: begin
               timer <= timer + 16'd1;
               if (bus.core_done) begin
                  digit_q   <= bus.core_digit;
                  tx_data_q <= digit_ascii(bus.core_digit, 1'b0);
               end else if (timed_out) begin
                  err       <= 1'b1;
                  tx_data_q <= digit_ascii(digit_q, 1'b1);
               end
            end
            TX_WAIT: if (bus.tx_done) err <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.tx_data = tx_data_q;
   assign bus.digit   = digit_q;
   assign bus.busy    = !((state == LOAD_WAIT) && (pix_cnt == '0));
   assign bus.state   = state;

endmodule

// File: tb/tb_snn_ctrl.sv
// Directed bench for snn_ctrl: image loads, result reporting, mux, timeout, reset.
module tb_snn_ctrl;
  import snn_pkg::*;

  localparam int NPIX = 784;
  localparam int NBYTES = NPIX / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  snn_ctrl_if #(.ADDR_W(10)) bus ();

  snn_ctrl #(.NUM_PIX(NPIX), .ADDR_W(10), .TIMEOUT_CYC(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: expected transmitted bytes
  logic [7:0] exp_q[$];

  // RAM model and monitor statistics
  logic mem [NPIX];
  int cyc = 0;
  int wr_cnt, exp_addr, addr_err, first_wr_addr, last_wr_cyc;
  int clr_cnt, start_cnt, start_cyc, tx_cnt, rw_cnt;
  logic [9:0] s_addr;
  logic s_we, s_clr, s_busy, s_txs;
  logic [3:0] s_digit;
  logic [7:0] s_txd;
  ctrl_state_t s_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; exp_addr = 0; addr_err = 0; first_wr_addr = -1; last_wr_cyc = 0;
    clr_cnt = 0; start_cnt = 0; start_cyc = 0; tx_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < NPIX; i++) mem[i] = 1'b0;
  endtask

  // samples DUT at negedge, returns just after the following posedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_addr = bus.ram_addr; s_we = bus.ram_we; s_clr = bus.clr_rx_rdy;
    s_busy = bus.busy; s_digit = bus.digit; s_txd = bus.tx_data;
    s_txs = bus.tx_start; s_state = bus.state;
    if (bus.ram_we) begin
      if (wr_cnt == 0) first_wr_addr = int'(bus.ram_addr);
      if (int'(bus.ram_addr) < NPIX) mem[bus.ram_addr] = bus.ram_d;
      if (int'(bus.ram_addr) != exp_addr) addr_err++;
      exp_addr++;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (bus.clr_rx_rdy) clr_cnt++;
    if (bus.core_start) begin start_cnt++; start_cyc = cyc; end
    if (bus.state == RUN_WAIT) rw_cnt++;
    if (bus.tx_start) begin
      tx_cnt++;
      if (exp_q.size() > 0) check("tx_data", bus.tx_data, exp_q.pop_front());
      else check("tx_unexpected", 32'(exp_q.size()), 1);
    end
    @(posedge clk);
    #1;
  endtask

  // driver: hold rx_rdy until the DUT consumes the byte
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data = b;
    bus.rx_rdy = 1'b1;
    do begin tick(); n++; end while (!s_clr && n < 40);
    if (!s_clr) check("rx_consume", 32'(s_clr), 1);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic load_bytes(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) send_byte(b);
  endtask

  task automatic wait_start();
    int n = 0;
    while (start_cnt == 0 && n < 30) begin tick(); n++; end
    check("start_seen", 32'(start_cnt), 1);
  endtask

  task automatic check_image(input string tag, input logic [7:0] first_b, input logic [7:0] rest_b);
    int bad = 0;
    logic [7:0] b;
    for (int i = 0; i < NPIX; i++) begin
      b = (i < 8) ? first_b : rest_b;
      if (mem[i] !== b[i % 8]) bad++;
    end
    check(tag, 32'(bad), 0);
  endtask

  task automatic run_result(input logic [3:0] d, input logic [7:0] e);
    bus.core_digit = d;
    bus.core_done = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.core_done = 1'b0;
    tick();
    check("res_tx_start", 32'(s_txs), 1);
    check("res_digit", 32'(s_digit), 32'(d));
    tick();
    check("res_tx_hold", 32'(s_txd), 32'(e));
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    check("res_busy_idle", 32'(s_busy), 0);
  endtask

  initial begin
    int n;
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.core_addr = '0;
    bus.core_done = 1'b0; bus.core_digit = 4'h0; bus.tx_done = 1'b0;
    clear_stats();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clr", 32'(bus.clr_rx_rdy), 0);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_d", 32'(bus.ram_d), 0);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_core_start", 32'(bus.core_start), 0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_digit", 32'(bus.digit), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // reset in the middle of LOAD_BITS at pixel 37
    load_bytes(8'hFF, 5);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.ram_we && bus.ram_addr == 10'd37) && n < 20);
    check("pre_rst_addr", 32'(bus.ram_addr), 37);
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(bus.ram_we), 0);
    check("mid_rst_addr", 32'(bus.ram_addr), 0);
    check("mid_rst_d", 32'(bus.ram_d), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_state", 32'(bus.state), 32'(LOAD_WAIT));
    @(posedge clk); #1;
    rst = 1'b0;

    // image 1: 98 x A5
    clear_stats();
    load_bytes(8'hA5, NBYTES);
    wait_start();
    check("img1_first_addr", 32'(first_wr_addr), 0);
    check("img1_wr_cnt", 32'(wr_cnt), 784);
    check("img1_addr_order", 32'(addr_err), 0);
    check("img1_clr_cnt", 32'(clr_cnt), 98);
    check("img1_start_lat", 32'(start_cyc - last_wr_cyc), 1);
    check_image("img1_bits", 8'hA5, 8'hA5);

    // mux during run, byte arriving mid-run stays pending
    bus.core_addr = 10'h2A5;
    bus.rx_data = 8'hFF;
    bus.rx_rdy = 1'b1;
    tick();
    check("mux_addr", 32'(s_addr), 32'h2A5);
    check("mux_we", 32'(s_we), 0);
    check("mux_state", 32'(s_state), 32'(RUN_WAIT));
    repeat (5) tick();
    check("run_rx_not_cleared", 32'(clr_cnt), 98);
    bus.core_digit = 4'd7;
    bus.core_done = 1'b1;
    exp_q.push_back(8'h37);
    tick();
    bus.core_done = 1'b0;
    tick();
    check("img1_tx_start", 32'(s_txs), 1);
    check("img1_digit", 32'(s_digit), 7);
    tick();
    check("img1_tx_hold", 32'(s_txd), 32'h37);
    check("img1_tx_wait", 32'(s_state), 32'(TX_WAIT));
    clear_stats();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    check("pending_rx_cleared", 32'(s_clr), 1);
    check("idle_busy", 32'(s_busy), 0);
    bus.rx_rdy = 1'b0;

    // image 2: FF (pending byte) then 97 x 3C, no core_done -> timeout
    load_bytes(8'h3C, NBYTES - 1);
    wait_start();
    check("img2_wr_cnt", 32'(wr_cnt), 784);
    check("img2_addr_order", 32'(addr_err), 0);
    check("img2_clr_cnt", 32'(clr_cnt), 98);
    check_image("img2_bits", 8'hFF, 8'h3C);
    bus.core_addr = '0;
    exp_q.push_back(8'h3F);
    n = 0;
    while (tx_cnt == 0 && n < 300) begin tick(); n++; end
    check("to_tx_seen", 32'(tx_cnt), 1);
    check("to_run_wait_cycles", 32'(rw_cnt), 101);
    check("to_digit_kept", 32'(s_digit), 7);
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    check("to_busy_idle", 32'(s_busy), 0);

    // image 3: normal report after a timeout
    clear_stats();
    load_bytes(8'h81, NBYTES);
    wait_start();
    check_image("img3_bits", 8'h81, 8'h81);
    run_result(4'd3, 8'h33);

    // image 4: out-of-range digit
    clear_stats();
    load_bytes(8'h5A, NBYTES);
    wait_start();
    run_result(4'hC, 8'h3F);

    check("tx_queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
